// File: rtl/line_window_3x3.sv
// line_window_3x3: 3x3 neighbourhood generator for a raster pixel stream.
// Pixels arrive one per enabled cycle, tagged with their row/column. Two line
// buffers hold the previous two rows. A 3x3 register window shifts left one
// column per pixel. The window, its centre coordinate and a valid flag are
// registered outputs with one cycle of latency.
module line_window_3x3 #(
  parameter int WIDTH      = 32,
  parameter int HEIGHT     = 32,
  parameter int DATA_WIDTH = 8,
  localparam int CW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1,
  localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic [CW-1:0]           column_counter,
  input  logic [RW-1:0]           row_counter,
  input  logic [DATA_WIDTH-1:0]   pixel_in,
  output logic [9*DATA_WIDTH-1:0] window,
  output logic                    window_valid,
  output logic [RW-1:0]           centre_row,
  output logic [CW-1:0]           centre_col
);

  // One extra bit so that WIDTH itself is representable when it is a power of two.
  localparam logic [CW:0] WIDTH_EXT = (CW+1)'(WIDTH);
  localparam logic [CW:0] COL_TWO   = (CW+1)'(2);
  localparam logic [RW:0] ROW_TWO   = (RW+1)'(2);

  // Line buffers: lb1 is the previous row, lb2 the row before that.
  // They carry no reset. Stale contents are masked by the valid gating.
  logic [DATA_WIDTH-1:0] lb1 [WIDTH];
  logic [DATA_WIDTH-1:0] lb2 [WIDTH];

  // Window element k = 3*r + c, where r=0 is the oldest row and c=0 the oldest column.
  logic [DATA_WIDTH-1:0] win_q [9];
  logic [DATA_WIDTH-1:0] win_d [9];
  logic                  valid_q;
  logic                  valid_d;
  logic [RW-1:0]         centre_row_q;
  logic [RW-1:0]         centre_row_d;
  logic [CW-1:0]         centre_col_q;
  logic [CW-1:0]         centre_col_d;

  logic                  col_in_range;
  logic                  col_ge2;
  logic                  row_ge2;
  logic                  shift_en;
  logic [CW-1:0]         rd_addr;
  logic [DATA_WIDTH-1:0] new_col [3];

  // Column compares and the read address. The address is clamped to 0 when
  // the column is outside the row, so no out-of-bounds array read occurs for
  // non-power-of-two widths.
  always_comb begin
    col_in_range = ({1'b0, column_counter} < WIDTH_EXT);
    col_ge2      = ({1'b0, column_counter} >= COL_TWO);
    row_ge2      = ({1'b0, row_counter} >= ROW_TWO);
    shift_en     = enable && col_in_range;
    rd_addr      = col_in_range ? column_counter : '0;
  end

  // Incoming window column, ordered oldest row first.
  // The line buffers are read before this cycle's write takes effect.
  always_comb begin
    new_col[0] = lb2[rd_addr];
    new_col[1] = lb1[rd_addr];
    new_col[2] = pixel_in;
  end

  // Line buffer update. Each row ages one buffer per pixel at the same
  // address as the read.
  always_ff @(posedge clk) begin
    if (shift_en) begin
      lb2[rd_addr] <= lb1[rd_addr];
      lb1[rd_addr] <= pixel_in;
    end
  end

  // Next-state for the window, the valid flag and the centre coordinate.
  always_comb begin
    win_d        = win_q;
    valid_d      = 1'b0;
    centre_row_d = centre_row_q;
    centre_col_d = centre_col_q;
    if (enable) begin
      // The coordinate tracks every accepted beat. It is only meaningful when valid.
      centre_row_d = row_counter - RW'(1);
      centre_col_d = column_counter - CW'(1);
      // Columns 0-1 would straddle a row boundary. Rows 0-1 lack a full history.
      valid_d      = row_ge2 && col_ge2 && col_in_range;
    end
    if (shift_en) begin
      for (int r = 0; r < 3; r++) begin
        win_d[3*r]     = win_q[3*r + 1];
        win_d[3*r + 1] = win_q[3*r + 2];
        win_d[3*r + 2] = new_col[r];
      end
    end
  end

  // Output registers with synchronous reset. The line buffers are left untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 9; k++) begin
        win_q[k] <= '0;
      end
      valid_q      <= 1'b0;
      centre_row_q <= '0;
      centre_col_q <= '0;
    end else begin
      win_q        <= win_d;
      valid_q      <= valid_d;
      centre_row_q <= centre_row_d;
      centre_col_q <= centre_col_d;
    end
  end

  // Flatten the window array onto the output bus.
  generate
    for (genvar gi = 0; gi < 9; gi++) begin : g_win_out
      assign window[gi*DATA_WIDTH +: DATA_WIDTH] = win_q[gi];
    end
  endgenerate

  assign window_valid = valid_q;
  assign centre_row   = centre_row_q;
  assign centre_col   = centre_col_q;

endmodule

// File: tb/tb_line_window_3x3.sv
// Testbench for line_window_3x3 (32x32, 8-bit pixels).
// Streams full frames and checks each output against a pixel-formula model.
// A table of hand-computed checkpoints is also checked. Hand-written
// sequences cover the enable gap and the mid-frame reset.
module tb_line_window_3x3;

  localparam int W  = 32;
  localparam int H  = 32;
  localparam int DW = 8;
  localparam int NV = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic [4:0]    column_counter;
  logic [4:0]    row_counter;
  logic [DW-1:0] pixel_in;
  logic [9*DW-1:0] window;
  logic          window_valid;
  logic [4:0]    centre_row;
  logic [4:0]    centre_col;

  always #5 clk = ~clk;

  line_window_3x3 #(.WIDTH(W), .HEIGHT(H), .DATA_WIDTH(DW)) dut (
    .clk            (clk),
    .rst            (rst),
    .enable         (enable),
    .column_counter (column_counter),
    .row_counter    (row_counter),
    .pixel_in       (pixel_in),
    .window         (window),
    .window_valid   (window_valid),
    .centre_row     (centre_row),
    .centre_col     (centre_col)
  );

  typedef struct {
    int tag;
    int row;
    int col;
    int exp_valid;
    int w0;
    int w4;
    int w8;
    int cr;
    int cc;
  } vec_t;

  vec_t tbl [NV];
  int   total = 0;
  int   bad   = 0;
  int   vcount;
  int   cur_tag;

  function automatic int pix(input int off, input int r, input int c);
    return (r * 32 + c + off) % 256;
  endfunction

  function automatic int win_el(input int k);
    return int'(window[k*DW +: DW]);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input bit r_v, input bit en, input int r, input int c, input int p);
    rst            = r_v;
    enable         = en;
    row_counter    = 5'(r);
    column_counter = 5'(c);
    pixel_in       = 8'(p);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_valid"}, int'(window_valid), 0);
    chk({tag, "_window_nonzero"}, (window != '0) ? 1 : 0, 0);
    chk({tag, "_centre_row"}, int'(centre_row), 0);
    chk({tag, "_centre_col"}, int'(centre_col), 0);
  endtask

  // Drive one enabled pixel. Check the output it produces against the model and the table.
  task automatic run_pixel(input int off, input int r, input int c, input bit rst_v, input bit check_win);
    int exp_v;
    step(rst_v, 1'b1, r, c, pix(off, r, c));
    if (window_valid) vcount++;
    if (rst_v) begin
      chk_reset_state($sformatf("rst_r%0d_c%0d", r, c));
    end else begin
      exp_v = (r >= 2 && c >= 2) ? 1 : 0;
      chk($sformatf("valid_r%0d_c%0d", r, c), int'(window_valid), exp_v);
      if (check_win && exp_v == 1) begin
        for (int k = 0; k < 9; k++) begin
          chk($sformatf("win%0d_r%0d_c%0d", k, r, c), win_el(k), pix(off, r - 2 + k / 3, c - 2 + k % 3));
        end
        chk($sformatf("crow_r%0d_c%0d", r, c), int'(centre_row), r - 1);
        chk($sformatf("ccol_r%0d_c%0d", r, c), int'(centre_col), c - 1);
      end
    end
    for (int i = 0; i < NV; i++) begin
      if (tbl[i].tag == cur_tag && tbl[i].row == r && tbl[i].col == c) begin
        chk($sformatf("tbl%0d_valid", i), int'(window_valid), tbl[i].exp_valid);
        if (tbl[i].exp_valid == 1) begin
          chk($sformatf("tbl%0d_w0", i), win_el(0), tbl[i].w0);
          chk($sformatf("tbl%0d_w4", i), win_el(4), tbl[i].w4);
          chk($sformatf("tbl%0d_w8", i), win_el(8), tbl[i].w8);
          chk($sformatf("tbl%0d_crow", i), int'(centre_row), tbl[i].cr);
          chk($sformatf("tbl%0d_ccol", i), int'(centre_col), tbl[i].cc);
        end
      end
    end
  endtask

  task automatic run_frame(input int off);
    vcount = 0;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        run_pixel(off, r, c, 1'b0, 1'b1);
      end
    end
  endtask

  initial begin
    // Columns: tag, row, col, valid, w0, w4, w8, centre_row, centre_col.
    tbl[0]  = '{0, 2, 2, 1, 0, 33, 66, 1, 1};
    tbl[1]  = '{0, 2, 1, 0, 0, 0, 0, 0, 0};
    tbl[2]  = '{0, 1, 31, 0, 0, 0, 0, 0, 0};
    tbl[3]  = '{0, 5, 0, 0, 0, 0, 0, 0, 0};
    tbl[4]  = '{0, 5, 1, 0, 0, 0, 0, 0, 0};
    tbl[5]  = '{0, 5, 2, 1, 96, 129, 162, 4, 1};
    tbl[6]  = '{0, 31, 31, 1, 189, 222, 255, 30, 30};
    tbl[7]  = '{1, 0, 5, 0, 0, 0, 0, 0, 0};
    tbl[8]  = '{1, 1, 31, 0, 0, 0, 0, 0, 0};
    tbl[9]  = '{1, 2, 2, 1, 100, 133, 166, 1, 1};
    tbl[10] = '{1, 2, 3, 1, 101, 134, 167, 1, 2};
    tbl[11] = '{1, 31, 31, 1, 33, 66, 99, 30, 30};

    // Reset held for two cycles with enable already high.
    cur_tag = -1;
    step(1'b1, 1'b1, 0, 0, 0);
    chk_reset_state("reset_cycle1");
    step(1'b1, 1'b1, 0, 0, 0);
    chk_reset_state("reset_cycle2");

    // Two back-to-back frames. The second has offset pixels to expose frame-wrap leakage.
    cur_tag = 0;
    run_frame(0);
    chk("frame1_valid_count", vcount, 900);
    cur_tag = 1;
    run_frame(100);
    chk("frame2_valid_count", vcount, 900);

    // Third frame: enable gap at row 4 col 10, then reset at row 10 col 7.
    cur_tag = 2;
    vcount  = 0;
    for (int r = 0; r <= 4; r++) begin
      for (int c = 0; c < ((r == 4) ? 11 : W); c++) begin
        run_pixel(0, r, c, 1'b0, 1'b1);
      end
    end
    for (int g = 0; g < 3; g++) begin
      step(1'b0, 1'b0, 7, 20, 8'hAA);
      chk($sformatf("gap%0d_valid", g), int'(window_valid), 0);
      for (int k = 0; k < 9; k++) begin
        chk($sformatf("gap%0d_win%0d", g, k), win_el(k), pix(0, 2 + k / 3, 8 + k % 3));
      end
      chk($sformatf("gap%0d_crow", g), int'(centre_row), 3);
      chk($sformatf("gap%0d_ccol", g), int'(centre_col), 9);
    end
    run_pixel(0, 4, 11, 1'b0, 1'b1);
    chk("after_gap_w8", win_el(8), 139);
    chk("after_gap_w7", win_el(7), 138);
    for (int c = 12; c < W; c++) run_pixel(0, 4, c, 1'b0, 1'b1);
    for (int r = 5; r <= 9; r++) begin
      for (int c = 0; c < W; c++) run_pixel(0, r, c, 1'b0, 1'b1);
    end
    for (int c = 0; c < 7; c++) run_pixel(0, 10, c, 1'b0, 1'b1);
    run_pixel(0, 10, 7, 1'b1, 1'b0);
    for (int c = 8; c < W; c++) run_pixel(0, 10, c, 1'b0, 1'b0);
    for (int r = 11; r <= 15; r++) begin
      for (int c = 0; c < W; c++) run_pixel(0, r, c, 1'b0, (r >= 13));
    end

    // An idle edge drops valid.
    step(1'b0, 1'b0, 15, 31, 0);
    chk("idle_valid", int'(window_valid), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
